mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style sequencing controller that turns the single-cycle MIPS datapath (Fetch, RegFile, Extender, ALU, 2:1 muxes) into a multi-cycle machine sharing one memory port for instruction and data.
- Generates per-state enables and mux selects from the latched IR opcode/funct and ALU Zero.
- Handles variable-latency memory via a ready handshake with a timeout.

Parameters:
- MAX_WAIT, 15, maximum cycles spent waiting for Mem_Ready in one memory state before timeout (1..255).
- CNT_W, 8, width of the wait counter; must hold MAX_WAIT.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Op  in  6  IR[31:26], stable from DECODE until the instruction completes.
- Func  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- Mem_Ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if Zero.
- IorD  out  1  0 = PC address, 1 = ALU-out address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  latch instruction register.
- MemtoReg  out  1  write-back source: 1 = MDR, 0 = ALU-out.
- RegDst  out  1  destination select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write enable.
- ExtOP  out  1  1 = sign extend, 0 = zero extend.
- ALUSrcA  out  1  0 = PC, 1 = Out1.
- ALUSrcB  out  2  00 = Out2, 01 = const 4, 10 = Ext_Imm, 11 = Ext_Imm<<2.
- ALU_ctr  out  3  ALU operation.
- PCSource  out  2  00 = ALU result, 01 = ALU-out, 10 = jump target.
- Instr_Done  out  1  one-cycle pulse on the final state of each instruction.
- Illegal  out  1  one-cycle pulse when an unsupported Op/Func is decoded.
- Mem_Timeout  out  1  sticky flag, cleared only by Reset.

Behaviour:
- Reset asynchronous: state = IDLE, wait counter = 0, Mem_Timeout = 0.
- All outputs 0 in IDLE. IDLE always advances to FETCH on the next edge.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALU_ctr = ADD, PCSource = 00.
  - IRWrite and PCWrite are asserted only in the cycle Mem_Ready = 1; that cycle the state moves to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALU_ctr = ADD, ExtOP = 1 (branch target precompute). Next state by Op:
  - R-type (000000) -> R_EXEC.
  - lw (100011) or sw (101011) -> MEM_ADDR.
  - beq (000100) -> BRANCH.
  - j (000010) -> JUMP.
  - addi (001000) or ori (001101) -> I_EXEC.
  - Anything else -> FETCH with Illegal = 1 in the DECODE cycle; PC is already advanced.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALU_ctr from Func:
  - 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR, 101010 -> SLT.
  - Any other Func: Illegal pulse, return to FETCH with no RegWrite.
  - Valid Func -> R_WB.
- R_WB: RegDst = 1, RegWrite = 1, MemtoReg = 0, Instr_Done = 1 -> FETCH.
- I_EXEC: ALUSrcA = 1, ALUSrcB = 10, ALU_ctr = ADD with ExtOP = 1 (addi) or OR with ExtOP = 0 (ori) -> I_WB.
- I_WB: RegDst = 0, RegWrite = 1, MemtoReg = 0, Instr_Done = 1 -> FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ExtOP = 1, ALU_ctr = ADD -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: MemRead = 1, IorD = 1; held until Mem_Ready, then -> MEM_WB.
- MEM_WB: RegDst = 0, MemtoReg = 1, RegWrite = 1, Instr_Done = 1 -> FETCH.
- MEM_WRITE: MemWrite = 1, IorD = 1; held until Mem_Ready. Instr_Done = 1 in the ready cycle -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALU_ctr = SUB, PCSource = 01, PCWriteCond = 1, Instr_Done = 1 -> FETCH.
- JUMP: PCSource = 10, PCWrite = 1, Instr_Done = 1 -> FETCH.
- Wait counter:
  - Cleared on entry to any memory state (FETCH, MEM_READ, MEM_WRITE).
  - Increments each cycle that state waits without Mem_Ready.
  - Reaching MAX_WAIT: set Mem_Timeout, drop the request, return to FETCH.
  - Timeout in FETCH: no PCWrite, so the same PC is refetched.
  - Timeout in MEM_READ/MEM_WRITE: the instruction is abandoned, with no RegWrite and no Instr_Done.
- Mem_Ready sampled outside memory states is ignored.
- Latency with zero-wait memory: lw 5, sw/R/addi/ori 4, beq/j 3 cycles.
- Reset mid-instruction aborts immediately; no partial write is issued after Reset asserts.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI;
  - funct constants;
  - ALU_ctr encodings AND = 000, OR = 001, ADD = 010, SUB = 110, SLT = 111;
  - ALUSrcB and PCSource encodings;
  - state enumeration.
- One natural sub-module: mips_alu_decode (combinational Op/Func/state-class -> ALU_ctr, ExtOP, Illegal), reused by the single-cycle Control_Unit.

Test Plan:
- Reset asserted mid-MEM_READ, released -> all outputs 0 for exactly one cycle (IDLE), then MemRead = 1 with IorD = 0.
- add $3,$1,$2 (0x00221820), Mem_Ready always 1 -> sequence FETCH, DECODE, R_EXEC, R_WB; ALU_ctr = 010 in R_EXEC; RegWrite = 1, RegDst = 1 and Instr_Done = 1 only in cycle 4.
- lw $2,8($1) (0x8C220008), Mem_Ready delayed 3 cycles in MEM_READ -> MemRead/IorD = 1 held 4 cycles; RegWrite = 1, MemtoReg = 1 one cycle later; total 8 cycles.
- beq (0x10220004) with Zero = 1, then Zero = 0 -> PCWriteCond = 1, PCSource = 01, ALU_ctr = 110 in both cases; completes in 3 cycles.
- Op = 111111 -> Illegal pulse in the DECODE cycle, no RegWrite/MemWrite, FETCH on the next cycle. R-type Func = 000000 -> Illegal in R_EXEC.
- Mem_Ready held 0 in FETCH with MAX_WAIT = 15 -> Mem_Timeout rises after 15 wait cycles, PCWrite never asserted; the flag stays 1 until Reset.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and the ALU decoder.
// Holds opcodes, funct codes, ALU/mux encodings and the state enumeration.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_OUT2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB,
    S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP
  } state_t;

  // Which ALU role the current state plays; lets the decoder be shared.
  typedef enum logic [2:0] {
    AC_NONE, AC_FETCH, AC_DECODE, AC_R_EXEC, AC_I_EXEC, AC_MEM_ADDR, AC_BRANCH
  } alu_class_t;

  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational ALU control decode from Op/Func and the state's ALU role.
// Also flags unsupported opcodes (decode role) and functs (R-exec role).
module mips_alu_decode
  import mips_pkg::*;
(
  input  alu_class_t  i_class,
  input  logic [5:0]  i_op,
  input  logic [5:0]  i_func,
  output logic [2:0]  o_alu_ctr,
  output logic        o_ext_op,
  output logic        o_illegal
);

  always_comb begin
    o_alu_ctr = ALU_AND;
    o_ext_op  = 1'b0;
    o_illegal = 1'b0;
    case (i_class)
      AC_FETCH: o_alu_ctr = ALU_ADD;
      AC_DECODE: begin
        o_alu_ctr = ALU_ADD;
        o_ext_op  = 1'b1;
        o_illegal = !(i_op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI});
      end
      AC_R_EXEC: begin
        case (i_func)
          FN_ADD:  o_alu_ctr = ALU_ADD;
          FN_SUB:  o_alu_ctr = ALU_SUB;
          FN_AND:  o_alu_ctr = ALU_AND;
          FN_OR:   o_alu_ctr = ALU_OR;
          FN_SLT:  o_alu_ctr = ALU_SLT;
          default: begin
            o_alu_ctr = ALU_ADD;
            o_illegal = 1'b1;
          end
        endcase
      end
      AC_I_EXEC: begin
        if (i_op == OP_ORI) begin
          o_alu_ctr = ALU_OR;
          o_ext_op  = 1'b0;
        end else begin
          o_alu_ctr = ALU_ADD;
          o_ext_op  = 1'b1;
        end
      end
      AC_MEM_ADDR: begin
        o_alu_ctr = ALU_ADD;
        o_ext_op  = 1'b1;
      end
      AC_BRANCH: o_alu_ctr = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller sharing one memory port, with a
// ready handshake and a sticky timeout on stalled memory accesses.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_ext_op,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_ctr,
  output logic [1:0] o_pc_source,
  output logic       o_instr_done,
  output logic       o_illegal,
  output logic       o_mem_timeout
);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  alu_class_t       w_class;
  logic             w_illegal;
  logic             w_waiting;
  logic             w_expired;
  // Zero acts only through PCWriteCond in the datapath; the FSM never branches on it.
  logic             w_zero_unused;

  assign w_zero_unused = i_zero;
  assign w_waiting     = is_mem_state(r_state) && !i_mem_ready;
  assign w_expired     = w_waiting && (r_cnt == CNT_W'(MAX_WAIT - 1));
  assign o_mem_timeout = r_timeout;
  assign o_illegal     = w_illegal;

  mips_alu_decode u_alu_decode (
    .i_class   (w_class),
    .i_op      (i_op),
    .i_func    (i_func),
    .o_alu_ctr (o_alu_ctr),
    .o_ext_op  (o_ext_op),
    .o_illegal (w_illegal)
  );

  // Counter is zero in every cycle that is not a continuing wait, so any
  // entry (or timeout re-entry) into a memory state starts from zero.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_waiting && !w_expired) r_cnt <= r_cnt + CNT_W'(1);
      else                         r_cnt <= '0;
      if (w_expired) r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_class         = AC_NONE;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SRCB_OUT2;
    o_pc_source     = PCS_ALU;
    o_instr_done    = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        w_class     = AC_FETCH;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_expired) begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        o_alu_src_b = SRCB_IMM_SH2;
        w_class     = AC_DECODE;
        case (i_op)
          OP_RTYPE:     w_next = S_R_EXEC;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI,
          OP_ORI:       w_next = S_I_EXEC;
          default:      w_next = S_FETCH;
        endcase
      end
      S_R_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_OUT2;
        w_class     = AC_R_EXEC;
        w_next      = w_illegal ? S_FETCH : S_R_WB;
      end
      S_R_WB: begin
        o_reg_dst    = 1'b1;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_I_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        w_class     = AC_I_EXEC;
        w_next      = S_I_WB;
      end
      S_I_WB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        w_class     = AC_MEM_ADDR;
        w_next      = (i_op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
        if (i_mem_ready)    w_next = S_MEM_WB;
        else if (w_expired) w_next = S_FETCH;
      end
      S_MEM_WB: begin
        o_mem_to_reg = 1'b1;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WRITE: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
        if (i_mem_ready) begin
          o_instr_done = 1'b1;
          w_next       = S_FETCH;
        end else if (w_expired) begin
          w_next = S_FETCH;
        end
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_src_b     = SRCB_OUT2;
        o_pc_source     = PCS_ALUOUT;
        o_pc_write_cond = 1'b1;
        o_instr_done    = 1'b1;
        w_class         = AC_BRANCH;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        o_pc_source  = PCS_JUMP;
        o_pc_write   = 1'b1;
        o_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: table of instructions with a responsive
// memory model and a scoreboard, plus reset and timeout sequences.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic       zero = 1'b0, ready = 1'b0;
  logic       pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, ext, srca, done, ill, tmo;
  logic [1:0] srcb, pcs;
  logic [2:0] alu;

  int checks = 0;
  int errors = 0;

  mips_multicycle_ctrl #(.MAX_WAIT(15), .CNT_W(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_op(op), .i_func(func), .i_zero(zero),
    .i_mem_ready(ready), .o_pc_write(pcw), .o_pc_write_cond(pcwc), .o_iord(iord),
    .o_mem_read(mr), .o_mem_write(mw), .o_ir_write(irw), .o_mem_to_reg(m2r),
    .o_reg_dst(rd), .o_reg_write(rw), .o_ext_op(ext), .o_alu_src_a(srca),
    .o_alu_src_b(srcb), .o_alu_ctr(alu), .o_pc_source(pcs), .o_instr_done(done),
    .o_illegal(ill), .o_mem_timeout(tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int op, func, zero, delay, cycles, alu3, ext3, pcs3, rw_cyc, rd_rw, m2r_rw,
        mw_cnt, iord_cnt, pcw_cnt, pcwc_cnt, done_cyc, ill_cyc;
  } vec_t;

  typedef struct {
    int cycles, alu3, ext3, pcs3, rw_cyc, rd_rw, m2r_rw,
        mw_cnt, iord_cnt, pcw_cnt, pcwc_cnt, done_cyc, ill_cyc;
  } obs_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] all_out();
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, ext, srca, srcb, alu, pcs, done, ill};
  endfunction

  // Starts at posedge+1 with the DUT in FETCH; ends when the next FETCH begins.
  task automatic run_instr(input vec_t v, output obs_t o);
    int cyc = 0;
    int req = 0;
    o = '{default: 0};
    while (cyc < 60) begin
      if (cyc > 0 && mr && !iord) break;
      op   = v.op[5:0];
      func = v.func[5:0];
      zero = v.zero[0];
      if (mr || mw) begin
        if (iord) begin
          ready = (req >= v.delay);
          req++;
        end else begin
          ready = 1'b1;
        end
      end else begin
        ready = 1'($urandom_range(0, 1));
        req   = 0;
      end
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin
        o.alu3 = int'(alu);
        o.ext3 = int'(ext);
        o.pcs3 = int'(pcs);
      end
      if (rw) begin
        o.rw_cyc = cyc;
        o.rd_rw  = int'(rd);
        o.m2r_rw = int'(m2r);
      end
      if (mw)   o.mw_cnt++;
      if (iord) o.iord_cnt++;
      if (pcw)  o.pcw_cnt++;
      if (pcwc) o.pcwc_cnt++;
      if (done) o.done_cyc = cyc;
      if (ill)  o.ill_cyc = cyc;
      @(posedge clk);
      #1;
    end
    ready    = 1'b0;
    o.cycles = cyc;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    obs_t o;
    vec_t e;
    string p;
    sb.push_back(v);
    run_instr(v, o);
    e = sb.pop_front();
    p = $sformatf("v%0d_op%02h", idx, e.op);
    chk({p, "_cycles"}, o.cycles, e.cycles);
    if (e.alu3 >= 0) chk({p, "_alu3"}, o.alu3, e.alu3);
    if (e.ext3 >= 0) chk({p, "_ext3"}, o.ext3, e.ext3);
    if (e.pcs3 >= 0) chk({p, "_pcs3"}, o.pcs3, e.pcs3);
    chk({p, "_rw_cyc"}, o.rw_cyc, e.rw_cyc);
    chk({p, "_regdst"}, o.rd_rw, e.rd_rw);
    chk({p, "_memtoreg"}, o.m2r_rw, e.m2r_rw);
    chk({p, "_memwrite_n"}, o.mw_cnt, e.mw_cnt);
    chk({p, "_iord_n"}, o.iord_cnt, e.iord_cnt);
    chk({p, "_pcwrite_n"}, o.pcw_cnt, e.pcw_cnt);
    chk({p, "_pcwcond_n"}, o.pcwc_cnt, e.pcwc_cnt);
    chk({p, "_done_cyc"}, o.done_cyc, e.done_cyc);
    chk({p, "_illegal_cyc"}, o.ill_cyc, e.ill_cyc);
  endtask

  initial begin
    int n;
    int pcw_seen;
    //              op    func  z  dly cyc alu ext pcs rwc rd m2r mw io pcw pcwc done ill
    vecs.push_back('{'h00, 'h20, 0, 0,  4,  2, -1, -1,  4, 1, 0,  0, 0, 1,  0,  4,  0}); // add
    vecs.push_back('{'h00, 'h22, 0, 0,  4,  6, -1, -1,  4, 1, 0,  0, 0, 1,  0,  4,  0}); // sub
    vecs.push_back('{'h00, 'h24, 0, 0,  4,  0, -1, -1,  4, 1, 0,  0, 0, 1,  0,  4,  0}); // and
    vecs.push_back('{'h00, 'h25, 0, 0,  4,  1, -1, -1,  4, 1, 0,  0, 0, 1,  0,  4,  0}); // or
    vecs.push_back('{'h00, 'h2a, 0, 0,  4,  7, -1, -1,  4, 1, 0,  0, 0, 1,  0,  4,  0}); // slt
    vecs.push_back('{'h23, 'h08, 0, 3,  8,  2,  1, -1,  8, 0, 1,  0, 4, 1,  0,  8,  0}); // lw slow
    vecs.push_back('{'h23, 'h08, 0, 0,  5,  2,  1, -1,  5, 0, 1,  0, 1, 1,  0,  5,  0}); // lw
    vecs.push_back('{'h2b, 'h08, 0, 0,  4,  2,  1, -1,  0, 0, 0,  1, 1, 1,  0,  4,  0}); // sw
    vecs.push_back('{'h2b, 'h08, 0, 2,  6,  2,  1, -1,  0, 0, 0,  3, 3, 1,  0,  6,  0}); // sw slow
    vecs.push_back('{'h04, 'h04, 1, 0,  3,  6, -1,  1,  0, 0, 0,  0, 0, 1,  1,  3,  0}); // beq Z=1
    vecs.push_back('{'h04, 'h04, 0, 0,  3,  6, -1,  1,  0, 0, 0,  0, 0, 1,  1,  3,  0}); // beq Z=0
    vecs.push_back('{'h02, 'h00, 0, 0,  3, -1, -1,  2,  0, 0, 0,  0, 0, 2,  0,  3,  0}); // j
    vecs.push_back('{'h08, 'h05, 0, 0,  4,  2,  1, -1,  4, 0, 0,  0, 0, 1,  0,  4,  0}); // addi
    vecs.push_back('{'h0d, 'h05, 0, 0,  4,  1,  0, -1,  4, 0, 0,  0, 0, 1,  0,  4,  0}); // ori
    vecs.push_back('{'h3f, 'h00, 0, 0,  2, -1, -1, -1,  0, 0, 0,  0, 0, 1,  0,  0,  2}); // bad op
    vecs.push_back('{'h00, 'h00, 0, 0,  3, -1, -1, -1,  0, 0, 0,  0, 0, 1,  0,  0,  3}); // bad func
    vecs.push_back('{'h23, 'h08, 0, 99, 18, 2,  1, -1,  0, 0, 0,  0, 15, 1, 0,  0,  0}); // lw timeout

    // Reset state, then one IDLE cycle of all-zero outputs, then FETCH.
    #12;
    chk("reset_outputs", int'(all_out()), 0);
    chk("reset_timeout", int'(tmo), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", int'(all_out()), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fetch_after_reset", int'({mr, iord}), 2);

    // FETCH with Mem_Ready held low: 15 wait cycles, then sticky timeout.
    n = 0;
    pcw_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (pcw) pcw_seen = 1;
      if (tmo) break;
      if (mr && !iord) n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("fetch_wait_cycles", n, 15);
    chk("fetch_timeout_flag", int'(tmo), 1);
    chk("fetch_timeout_no_pcwrite", pcw_seen, 0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], i);
    chk("timeout_sticky", int'(tmo), 1);

    // Reset in the middle of a lw MEM_READ wait.
    op = 6'h23; func = 6'h08; ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("memread_before_reset", int'({mr, iord}), 3);
    #2 rst = 1'b1;
    #1;
    chk("reset_mid_memread", int'(all_out()), 0);
    chk("reset_clears_timeout", int'(tmo), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_midreset", int'(all_out()), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fetch_after_midreset", int'({mr, iord}), 2);
    @(posedge clk); #1;
    run_vec(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
